// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: load-use stalls, branch squash,
// debug pause/run/step FSM and HALT drain. Define PIPELINE_CTRL_PERF_EN to build o_cycle_cnt.
module pipeline_ctrl #(
    parameter int NB_REG       = 5,
    parameter int DRAIN_CYCLES = 3,
    parameter int NB_CNT       = 16
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic [NB_REG-1:0] i_id_rs,
    input  logic [NB_REG-1:0] i_id_rt,
    input  logic [NB_REG-1:0] i_ex_rt,
    input  logic              i_ex_memRead,
    input  logic              i_branch_taken,
    input  logic              i_halt_id,
    input  logic              i_dbg_run,
    input  logic              i_dbg_stop,
    input  logic              i_dbg_step,
    output logic              o_pc_stall,
    output logic              o_ifid_stall,
    output logic              o_ifid_flush,
    output logic              o_idex_bubble,
    output logic [2:0]        o_state,
    output logic              o_step_done,
    output logic              o_halted,
    output logic [NB_CNT-1:0] o_stall_cnt,
    output logic [NB_CNT-1:0] o_cycle_cnt
);

    typedef enum logic [2:0] {
        ST_PAUSE  = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    localparam int                NB_DRN   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [NB_DRN-1:0] DRN_LAST = NB_DRN'(DRAIN_CYCLES - 1);

    state_t            state_q, state_d;
    logic [NB_DRN-1:0] drain_q;
    logic [NB_CNT-1:0] stall_cnt_q;
    logic              step_done_q;
    logic              hazard, active, stall_hit;

    // Register 0 is hardwired, so a load targeting it can never create a dependency.
    assign hazard    = i_ex_memRead && (i_ex_rt != '0) &&
                       ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));
    assign active    = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign stall_hit = active && hazard && !i_branch_taken;

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        state_d       = state_q;
        o_pc_stall    = 1'b0;
        o_ifid_stall  = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_bubble = 1'b0;
        case (state_q)
            ST_PAUSE: begin
                o_pc_stall    = 1'b1;
                o_ifid_stall  = 1'b1;
                o_idex_bubble = 1'b1;
                if (i_dbg_run)       state_d = ST_RUN;
                else if (i_dbg_step) state_d = ST_STEP;
            end
            ST_RUN, ST_STEP: begin
                // A taken branch squashes the dependent fetch, so it beats the stall.
                if (i_branch_taken) begin
                    o_ifid_flush  = 1'b1;
                    o_idex_bubble = 1'b1;
                end else if (hazard) begin
                    o_pc_stall    = 1'b1;
                    o_ifid_stall  = 1'b1;
                    o_idex_bubble = 1'b1;
                end
                if (i_halt_id)                                state_d = ST_DRAIN;
                else if (state_q == ST_RUN && i_dbg_stop)     state_d = ST_PAUSE;
                else if (state_q == ST_STEP && !stall_hit)    state_d = ST_PAUSE;
            end
            ST_DRAIN: begin
                o_pc_stall    = 1'b1;
                o_ifid_stall  = 1'b1;
                o_idex_bubble = 1'b1;
                if (drain_q == DRN_LAST) state_d = ST_HALTED;
            end
            ST_HALTED: begin
                o_pc_stall    = 1'b1;
                o_ifid_stall  = 1'b1;
                o_idex_bubble = 1'b1;
            end
            default: state_d = ST_PAUSE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_PAUSE;
            drain_q     <= '0;
            stall_cnt_q <= '0;
            step_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of its peers.
            state_q     <= state_d;
            step_done_q <= (state_q == ST_STEP) && !i_halt_id && !stall_hit;
            if (state_q != ST_DRAIN)     drain_q <= '0;
            else if (drain_q != DRN_LAST) drain_q <= drain_q + 1'b1;
            if (stall_hit && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    logic [NB_CNT-1:0] cycle_cnt_q;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n)                          cycle_cnt_q <= '0;
        else if (active && cycle_cnt_q != '1)  cycle_cnt_q <= cycle_cnt_q + 1'b1;
    end

    assign o_cycle_cnt = cycle_cnt_q;
`else
    assign o_cycle_cnt = '0;
`endif

    assign o_state     = state_q;
    assign o_step_done = step_done_q;
    assign o_halted    = (state_q == ST_HALTED);
    assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the driver queues hand-computed expectations
// per cycle and a negedge monitor pops and compares them against the DUT.
module tb_pipeline_ctrl;

    localparam int NB_REG = 5;
    localparam int NB_CNT = 8;   // reduced width so saturation is reached quickly

    localparam logic [2:0] S_PAUSE  = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_STEP   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    logic              clk = 1'b0;
    logic              i_rst_n;
    logic [NB_REG-1:0] i_id_rs, i_id_rt, i_ex_rt;
    logic              i_ex_memRead, i_branch_taken, i_halt_id;
    logic              i_dbg_run, i_dbg_stop, i_dbg_step;
    logic              o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_bubble;
    logic [2:0]        o_state;
    logic              o_step_done, o_halted;
    logic [NB_CNT-1:0] o_stall_cnt, o_cycle_cnt;

    pipeline_ctrl #(.NB_REG(NB_REG), .DRAIN_CYCLES(3), .NB_CNT(NB_CNT)) dut (
        .clk           (clk),
        .i_rst_n       (i_rst_n),
        .i_id_rs       (i_id_rs),
        .i_id_rt       (i_id_rt),
        .i_ex_rt       (i_ex_rt),
        .i_ex_memRead  (i_ex_memRead),
        .i_branch_taken(i_branch_taken),
        .i_halt_id     (i_halt_id),
        .i_dbg_run     (i_dbg_run),
        .i_dbg_stop    (i_dbg_stop),
        .i_dbg_step    (i_dbg_step),
        .o_pc_stall    (o_pc_stall),
        .o_ifid_stall  (o_ifid_stall),
        .o_ifid_flush  (o_ifid_flush),
        .o_idex_bubble (o_idex_bubble),
        .o_state       (o_state),
        .o_step_done   (o_step_done),
        .o_halted      (o_halted),
        .o_stall_cnt   (o_stall_cnt),
        .o_cycle_cnt   (o_cycle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic [2:0]        state;
        logic              stall;
        logic              flush;
        logic              bubble;
        logic              step_done;
        logic              halted;
        logic [NB_CNT-1:0] stall_cnt;
        logic [NB_CNT-1:0] cycle_cnt;
    } exp_t;

    exp_t              sb[$];
    int                checks = 0;
    int                errors = 0;
    logic [NB_CNT-1:0] exp_cyc = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Drives one cycle of inputs and queues the outputs expected during that cycle.
    task automatic drive(input string nm,
                         input logic [NB_REG-1:0] rs, input logic [NB_REG-1:0] rt,
                         input logic [NB_REG-1:0] ex_rt, input logic mr, input logic br,
                         input logic hlt, input logic run, input logic stp, input logic stop,
                         input logic [2:0] e_st, input logic e_stall, input logic e_flush,
                         input logic e_bub, input logic e_sd, input logic [NB_CNT-1:0] e_scnt);
        exp_t e;
        i_id_rs = rs; i_id_rt = rt; i_ex_rt = ex_rt; i_ex_memRead = mr;
        i_branch_taken = br; i_halt_id = hlt;
        i_dbg_run = run; i_dbg_step = stp; i_dbg_stop = stop;
        e.name = nm; e.state = e_st; e.stall = e_stall; e.flush = e_flush;
        e.bubble = e_bub; e.step_done = e_sd; e.halted = (e_st == S_HALTED);
        e.stall_cnt = e_scnt;
`ifdef PIPELINE_CTRL_PERF_EN
        e.cycle_cnt = exp_cyc;
`else
        e.cycle_cnt = '0;
`endif
        sb.push_back(e);
        if ((e_st == S_RUN || e_st == S_STEP) && i_rst_n && exp_cyc != '1) exp_cyc++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, ".state"},      32'(o_state),       32'(e.state));
            check({e.name, ".pc_stall"},   32'(o_pc_stall),    32'(e.stall));
            check({e.name, ".ifid_stall"}, 32'(o_ifid_stall),  32'(e.stall));
            check({e.name, ".flush"},      32'(o_ifid_flush),  32'(e.flush));
            check({e.name, ".bubble"},     32'(o_idex_bubble), 32'(e.bubble));
            check({e.name, ".step_done"},  32'(o_step_done),   32'(e.step_done));
            check({e.name, ".halted"},     32'(o_halted),      32'(e.halted));
            check({e.name, ".stall_cnt"},  32'(o_stall_cnt),   32'(e.stall_cnt));
            check({e.name, ".cycle_cnt"},  32'(o_cycle_cnt),   32'(e.cycle_cnt));
        end
    end

    initial begin
        i_rst_n = 1'b0;
        i_id_rs = '0; i_id_rt = '0; i_ex_rt = '0; i_ex_memRead = 1'b0;
        i_branch_taken = 1'b0; i_halt_id = 1'b0;
        i_dbg_run = 1'b0; i_dbg_stop = 1'b0; i_dbg_step = 1'b0;
        repeat (2) @(posedge clk);
        #1 i_rst_n = 1'b1;

        //     name                rs rt ex mr br ht rn sp st  state   stl fl bub sd scnt
        drive("rst_idle",          0, 0, 0, 0, 0, 0, 0, 0, 0, S_PAUSE, 1, 0, 1, 0, 0);
        drive("pause_stop_ign",    0, 0, 0, 0, 0, 0, 0, 0, 1, S_PAUSE, 1, 0, 1, 0, 0);
        drive("pause_run",         0, 0, 0, 0, 0, 0, 1, 0, 0, S_PAUSE, 1, 0, 1, 0, 0);
        drive("run_idle",          0, 0, 0, 0, 0, 0, 0, 0, 0, S_RUN,   0, 0, 0, 0, 0);
        drive("run_hazard_rs",     5, 0, 5, 1, 0, 0, 0, 0, 0, S_RUN,   1, 0, 1, 0, 0);
        drive("run_ex_rt_zero",    5, 0, 0, 1, 0, 0, 0, 0, 0, S_RUN,   0, 0, 0, 0, 1);
        drive("run_hazard_rt",     0, 7, 7, 1, 0, 0, 0, 0, 0, S_RUN,   1, 0, 1, 0, 1);
        drive("run_no_load",       5, 0, 5, 0, 0, 0, 0, 0, 0, S_RUN,   0, 0, 0, 0, 2);
        drive("run_branch_hazard", 5, 0, 5, 1, 1, 0, 0, 0, 0, S_RUN,   0, 1, 1, 0, 2);
        drive("run_stop",          0, 0, 0, 0, 0, 0, 0, 0, 1, S_RUN,   0, 0, 0, 0, 2);
        drive("pause_step_hz",     5, 0, 5, 1, 0, 0, 0, 1, 0, S_PAUSE, 1, 0, 1, 0, 2);
        drive("step_hazard_1",     5, 0, 5, 1, 0, 0, 0, 0, 0, S_STEP,  1, 0, 1, 0, 2);
        drive("step_hazard_2",     5, 0, 5, 1, 0, 0, 0, 0, 0, S_STEP,  1, 0, 1, 0, 3);
        drive("step_complete",     0, 0, 0, 0, 0, 0, 0, 0, 0, S_STEP,  0, 0, 0, 0, 4);
        drive("step_done_pulse",   0, 0, 0, 0, 0, 0, 0, 0, 0, S_PAUSE, 1, 0, 1, 1, 4);
        drive("step_done_clear",   0, 0, 0, 0, 0, 0, 0, 0, 0, S_PAUSE, 1, 0, 1, 0, 4);
        drive("pause_run_step",    0, 0, 0, 0, 0, 0, 1, 1, 0, S_PAUSE, 1, 0, 1, 0, 4);
        drive("run_halt_stop",     0, 0, 0, 0, 0, 1, 0, 0, 1, S_RUN,   0, 0, 0, 0, 4);
        drive("drain_1_run_ign",   0, 0, 0, 0, 0, 0, 1, 0, 0, S_DRAIN, 1, 0, 1, 0, 4);
        drive("drain_2_step_ign",  0, 0, 0, 0, 0, 0, 0, 1, 0, S_DRAIN, 1, 0, 1, 0, 4);
        drive("drain_3",           0, 0, 0, 0, 0, 0, 0, 0, 0, S_DRAIN, 1, 0, 1, 0, 4);
        drive("halted_run_ign",    0, 0, 0, 0, 0, 0, 1, 0, 0, S_HALTED,1, 0, 1, 0, 4);
        drive("halted_hold",       0, 0, 0, 0, 0, 0, 0, 0, 0, S_HALTED,1, 0, 1, 0, 4);

        // Asynchronous reset from HALTED, then a step interrupted by HALT.
        i_rst_n = 1'b0;
        exp_cyc = '0;
        drive("async_rst_1",       0, 0, 0, 0, 0, 0, 0, 0, 0, S_PAUSE, 1, 0, 1, 0, 0);
        i_rst_n = 1'b1;
        drive("pause_step",        0, 0, 0, 0, 0, 0, 0, 1, 0, S_PAUSE, 1, 0, 1, 0, 0);
        drive("step_halt",         0, 0, 0, 0, 0, 1, 0, 0, 0, S_STEP,  0, 0, 0, 0, 0);
        drive("drain_no_sd",       0, 0, 0, 0, 0, 0, 0, 0, 0, S_DRAIN, 1, 0, 1, 0, 0);

        // Asynchronous reset from DRAIN, then drive the stall counter past saturation.
        i_rst_n = 1'b0;
        exp_cyc = '0;
        drive("async_rst_2",       0, 0, 0, 0, 0, 0, 0, 0, 0, S_PAUSE, 1, 0, 1, 0, 0);
        i_rst_n = 1'b1;
        drive("sat_run",           0, 0, 0, 0, 0, 0, 1, 0, 0, S_PAUSE, 1, 0, 1, 0, 0);
        for (int k = 0; k < 300; k++) begin
            drive("sat_hazard", 9, 3, 9, 1, 0, 0, 0, 0, 0, S_RUN, 1, 0, 1, 0,
                  (k > 255) ? NB_CNT'(255) : NB_CNT'(k));
        end
        drive("sat_hold",          0, 0, 0, 0, 0, 0, 0, 0, 0, S_RUN,   0, 0, 0, 0, 255);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencer for the 5-stage MIPS pipeline. It drives PC/IF-ID stall, IF-ID flush and ID-EX bubble controls.
- Detects load-use hazards against the instruction in decode and squashes wrong-path fetches on taken branches/jumps.
- Runs a debug execution FSM (pause/run/step) and drains the pipeline on a HALT instruction.
- Sits beside instruction_decode; its stall output feeds the decode i_stall input.

Parameters:
- NB_REG, 5, register address width
- DRAIN_CYCLES, 3, cycles to drain EX/MEM/WB after HALT before declaring halted
- NB_CNT, 16, width of performance counters

Ports:
- clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_id_rs  in  NB_REG  rs field of the instruction in IF/ID
- i_id_rt  in  NB_REG  rt field of the instruction in IF/ID
- i_ex_rt  in  NB_REG  rt of the instruction in ID/EX
- i_ex_memRead  in  1  ID/EX instruction is a load
- i_branch_taken  in  1  branch/jump resolved taken this cycle
- i_halt_id  in  1  HALT opcode present in IF/ID
- i_dbg_run  in  1  debug run command (1-cycle pulse)
- i_dbg_stop  in  1  debug pause command (pulse)
- i_dbg_step  in  1  debug single-step command (pulse)
- o_pc_stall  out  1  hold PC
- o_ifid_stall  out  1  hold IF/ID register
- o_ifid_flush  out  1  clear IF/ID to NOP
- o_idex_bubble  out  1  load NOP/zero controls into ID/EX
- o_state  out  3  current FSM state encoding
- o_step_done  out  1  registered 1-cycle pulse after a step completes
- o_halted  out  1  pipeline halted
- o_stall_cnt  out  NB_CNT  load-use stall cycles, saturating
- o_cycle_cnt  out  NB_CNT  RUN/STEP cycles (see feature)

Behaviour:
- States: PAUSE=0 (reset), RUN=1, STEP=2, DRAIN=3, HALTED=4. The state register is asynchronous-reset to PAUSE.
- Control outputs are combinational from state and inputs. Counters and o_step_done are registered.
- Reset values: o_step_done=0, o_halted=0, all counters=0. In PAUSE, the freeze outputs are 1 (see PAUSE).
- Definition: hazard = i_ex_memRead && i_ex_rt!=0 && (i_ex_rt==i_id_rs || i_ex_rt==i_id_rt).

PAUSE:
- pc_stall=1, ifid_stall=1, idex_bubble=1, ifid_flush=0.
- i_dbg_run moves to RUN.
- Otherwise i_dbg_step moves to STEP. Run wins if run and step arrive in the same cycle.
- i_dbg_stop is ignored.

RUN:
- Taken branch (i_branch_taken=1): ifid_flush=1, idex_bubble=1, no stalls. A flush overrides a simultaneous hazard.
- Hazard without a branch: pc_stall=1, ifid_stall=1, idex_bubble=1 for that cycle. o_stall_cnt increments.
- i_halt_id moves to DRAIN. This takes priority over i_dbg_stop and over a hazard.
- i_dbg_stop moves to PAUSE.

STEP:
- Same control rules as RUN.
- If a hazard stalls the cycle, the FSM stays in STEP.
- Otherwise it returns to PAUSE and o_step_done pulses the next cycle.
- i_halt_id moves to DRAIN with no step_done.

DRAIN:
- pc_stall=1, ifid_stall=1, idex_bubble=1.
- An internal counter loads 0 on entry. After DRAIN_CYCLES cycles the FSM moves to HALTED.
- All debug commands are ignored.

HALTED:
- Same freeze outputs as DRAIN, with o_halted=1.
- The only exit is reset.

Counters:
- o_stall_cnt saturates at all-ones and never wraps.
- Asynchronous reset at any point returns the FSM to PAUSE with all counters 0.

Optional Feature:
- Macro PIPELINE_CTRL_PERF_EN.
- Defined: o_cycle_cnt increments every cycle in RUN or STEP and saturates at all-ones.
- Undefined: o_cycle_cnt is tied to 0 and its register is not built. o_stall_cnt is always present.

Test Plan:
- Reset → state=PAUSE, pc_stall=ifid_stall=idex_bubble=1, halted=0. Then pulse i_dbg_run → state=RUN next cycle, all controls 0.
- RUN, i_ex_memRead=1, i_ex_rt=5, i_id_rs=5 for one cycle → pc_stall=ifid_stall=idex_bubble=1 that cycle, o_stall_cnt=1. The same stimulus with i_ex_rt=0 produces no stall.
- RUN, hazard and i_branch_taken=1 together → ifid_flush=1, idex_bubble=1, pc_stall=0, o_stall_cnt unchanged.
- PAUSE, i_dbg_step while a hazard is active for 2 cycles → stays in STEP for 2 cycles, then PAUSE, o_step_done=1 for exactly 1 cycle.
- RUN, i_halt_id=1 and i_dbg_stop=1 together → DRAIN, then after 3 cycles HALTED with o_halted=1. A later i_dbg_run leaves the FSM in HALTED.
- Force o_stall_cnt to 16'hFFFF via repeated hazards (or a reduced NB_CNT=4 build: 20 stalls) → counter holds at max. Under PIPELINE_CTRL_PERF_EN, o_cycle_cnt equals the number of RUN/STEP cycles; without the macro it stays 0.
